// File: rtl/clk_div_cfg_if.sv
// Ratio-change request bus between the register file and the divider config sequencer.
// The sequencer also drives the divider's ratio/enable and reports done/error pulses here.
interface clk_div_cfg_if #(
    parameter int RATIO_WIDTH = 8
);
    logic                   cfg_valid;
    logic [RATIO_WIDTH-1:0] cfg_ratio;
    logic                   cfg_ready;
    logic [RATIO_WIDTH-1:0] div_ratio;
    logic                   clk_en;
    logic                   cfg_done;
    logic                   cfg_err;

    modport master (
        output cfg_valid, cfg_ratio,
        input  cfg_ready, div_ratio, clk_en, cfg_done, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ratio,
        output cfg_ready, div_ratio, clk_en, cfg_done, cfg_err
    );
endinterface

// File: rtl/clk_div_cfg_ctrl.sv
// Config sequencer for the programmable clock divider: gates the divider, swaps the ratio, settles, re-enables.
// Optional macro DIV_RATIO_ODD_ROUND_EN: odd ratios >=3 are rounded down to even instead of rejected.
module clk_div_cfg_ctrl #(
    parameter int RATIO_WIDTH   = 8,
    parameter int DEFAULT_RATIO = 8,
    parameter int GATE_CYCLES   = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic          I_ref_clk,
    input  logic          I_rst_n,
    clk_div_cfg_if.slave  cfg
);
    localparam int MAX_CYCLES = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0]       GATE_LAST   = CNT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]       SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [RATIO_WIDTH-1:0] RESET_RATIO = RATIO_WIDTH'(DEFAULT_RATIO);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_GATE   = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [RATIO_WIDTH-1:0] ratio_q, ratio_d;
    logic [RATIO_WIDTH-1:0] pend_q, pend_d;
    logic                   clk_en_q, clk_en_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   from_req_q, from_req_d;

    logic                   accept;
    logic                   req_odd;
    logic                   req_bad;
    logic [RATIO_WIDTH-1:0] req_ratio;

    assign cfg.cfg_ready = (state_q == ST_RUN);
    assign cfg.div_ratio = ratio_q;
    assign cfg.clk_en    = clk_en_q;
    assign cfg.cfg_done  = done_q;
    assign cfg.cfg_err   = err_q;

    assign accept  = cfg.cfg_valid && (state_q == ST_RUN);
    // 0 and 1 are legal (1 = bypass); only odd values of 3 and above are a problem
    assign req_odd = cfg.cfg_ratio[0] && (cfg.cfg_ratio > RATIO_WIDTH'(1));

`ifdef DIV_RATIO_ODD_ROUND_EN
    assign req_ratio = req_odd ? {cfg.cfg_ratio[RATIO_WIDTH-1:1], 1'b0} : cfg.cfg_ratio;
    assign req_bad   = 1'b0;
`else
    assign req_ratio = cfg.cfg_ratio;
    assign req_bad   = req_odd;
`endif

    always_ff @(posedge I_ref_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q    <= ST_SETTLE;
            cnt_q      <= '0;
            ratio_q    <= RESET_RATIO;
            pend_q     <= RESET_RATIO;
            clk_en_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            from_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ratio_q    <= ratio_d;
            pend_q     <= pend_d;
            clk_en_q   <= clk_en_d;
            done_q     <= done_d;
            err_q      <= err_d;
            from_req_q <= from_req_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ratio_d    = ratio_q;
        pend_d     = pend_q;
        clk_en_d   = clk_en_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        from_req_d = from_req_q;

        case (state_q)
            ST_RUN: begin
                if (accept) begin
                    if (req_bad) begin
                        err_d = 1'b1;
                    end else if (req_ratio == ratio_q) begin
                        done_d = 1'b1;
                    end else begin
                        pend_d     = req_ratio;
                        state_d    = ST_GATE;
                        cnt_d      = '0;
                        clk_en_d   = 1'b0;
                        from_req_d = 1'b1;
                    end
                end
            end
            ST_GATE: begin
                if (cnt_q == GATE_LAST) begin
                    ratio_d = pend_q;
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                // The post-reset settle ends silently; only a real request reports done
                if (cnt_q == SETTLE_LAST) begin
                    state_d    = ST_RUN;
                    cnt_d      = '0;
                    clk_en_d   = 1'b1;
                    done_d     = from_req_q;
                    from_req_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d  = ST_SETTLE;
                cnt_d    = '0;
                clk_en_d = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// Self-checking bench for clk_div_cfg_ctrl: scoreboard of expected request outcomes, one task per scenario.
module tb_clk_div_cfg_ctrl;
    localparam int G = 2;
    localparam int S = 2;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] model_ratio = 8'd8;

    typedef struct {
        bit         is_err;
        bit         gated;
        logic [7:0] old_ratio;
        logic [7:0] new_ratio;
        int         lat;
    } exp_t;
    exp_t sb[$];

    clk_div_cfg_if #(.RATIO_WIDTH(8)) bus ();

    clk_div_cfg_ctrl #(
        .RATIO_WIDTH  (8),
        .DEFAULT_RATIO(8),
        .GATE_CYCLES  (G),
        .SETTLE_CYCLES(S)
    ) dut (
        .I_ref_clk(clk),
        .I_rst_n  (rst_n),
        .cfg      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic reset_seq();
        rst_n = 1'b0;
        bus.cfg_valid = 1'b0;
        sb.delete();
        model_ratio = 8'd8;
        @(negedge clk);
        checks++; if (bus.div_ratio !== 8'd8) begin errors++; $display("FAIL rst_ratio: got %0d expected 8", bus.div_ratio); end
        checks++; if (bus.clk_en !== 1'b0) begin errors++; $display("FAIL rst_clk_en: got %b expected 0", bus.clk_en); end
        checks++; if (bus.cfg_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", bus.cfg_ready); end
        checks++; if (bus.cfg_done !== 1'b0 || bus.cfg_err !== 1'b0) begin errors++; $display("FAIL rst_pulses: got done=%b err=%b expected 0/0", bus.cfg_done, bus.cfg_err); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.clk_en !== 1'b0 || bus.cfg_ready !== 1'b0) begin errors++; $display("FAIL settle_edge1: got en=%b rdy=%b expected 0/0", bus.clk_en, bus.cfg_ready); end
        @(negedge clk);
        checks++; if (bus.clk_en !== 1'b1 || bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL settle_edge2: got en=%b rdy=%b expected 1/1", bus.clk_en, bus.cfg_ready); end
        checks++; if (bus.div_ratio !== 8'd8 || bus.cfg_done !== 1'b0) begin errors++; $display("FAIL settle_ratio_done: got ratio=%0d done=%b expected 8/0", bus.div_ratio, bus.cfg_done); end
        $display("reset sequence: ratio=%0d clk_en=%b ready=%b", bus.div_ratio, bus.clk_en, bus.cfg_ready);
    endtask

    // Called at a negedge; holds the request until ready, then records the expected outcome.
    task automatic accept(input logic [7:0] r, input bit keep, input logic [7:0] nxt, output int waited);
        exp_t       e;
        logic [7:0] eff;
        bus.cfg_valid = 1'b1;
        bus.cfg_ratio = r;
        waited = 0;
        while (bus.cfg_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) begin
            checks++; errors++;
            $display("FAIL accept_timeout: ready got %b expected 1 within 20 cycles", bus.cfg_ready);
            bus.cfg_valid = 1'b0;
            return;
        end
        @(posedge clk);
        eff = r;
        e.is_err = 1'b0;
        if (r > 8'd1 && r[0]) begin
`ifdef DIV_RATIO_ODD_ROUND_EN
            eff = r & 8'hFE;
`else
            e.is_err = 1'b1;
`endif
        end
        e.old_ratio = model_ratio;
        e.new_ratio = e.is_err ? model_ratio : eff;
        e.gated     = !e.is_err && (eff != model_ratio);
        e.lat       = e.gated ? (G + S + 1) : 1;
        model_ratio = e.new_ratio;
        sb.push_back(e);
        #1;
        if (keep) bus.cfg_ratio = nxt;
        else      bus.cfg_valid = 1'b0;
    endtask

    task automatic check_resp(input bit chk_pulse);
        exp_t e;
        int   n;
        bit   seen;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_empty: got 0 entries expected 1");
            return;
        end
        e = sb.pop_front();
        n = 0;
        seen = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            checks++; if (bus.cfg_done === 1'b1 && bus.cfg_err === 1'b1) begin errors++; $display("FAIL done_err_both: got 1/1 expected not both"); end
            if (bus.cfg_done === 1'b1 || bus.cfg_err === 1'b1) begin
                seen = 1;
            end else if (e.gated) begin
                checks++; if (bus.clk_en !== 1'b0 || bus.cfg_ready !== 1'b0) begin errors++; $display("FAIL gate_en_rdy n=%0d: got en=%b rdy=%b expected 0/0", n, bus.clk_en, bus.cfg_ready); end
                checks++; if (bus.div_ratio !== ((n <= G) ? e.old_ratio : e.new_ratio)) begin errors++; $display("FAIL gate_ratio n=%0d: got %0d expected %0d", n, bus.div_ratio, (n <= G) ? e.old_ratio : e.new_ratio); end
            end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL resp_timeout: got no done/err expected one within 20 cycles");
            return;
        end
        checks++; if (n != e.lat) begin errors++; $display("FAIL resp_latency: got %0d expected %0d", n, e.lat); end
        checks++; if (bus.cfg_err !== e.is_err || bus.cfg_done !== !e.is_err) begin errors++; $display("FAIL resp_kind: got done=%b err=%b expected err=%b", bus.cfg_done, bus.cfg_err, e.is_err); end
        checks++; if (bus.div_ratio !== e.new_ratio) begin errors++; $display("FAIL resp_ratio: got %0d expected %0d", bus.div_ratio, e.new_ratio); end
        checks++; if (bus.clk_en !== 1'b1 || bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL resp_en_rdy: got en=%b rdy=%b expected 1/1", bus.clk_en, bus.cfg_ready); end
        $display("request resolved: %s after %0d cycles, ratio=%0d", e.is_err ? "err" : "done", n, bus.div_ratio);
        if (chk_pulse) begin
            @(negedge clk);
            checks++; if (bus.cfg_done !== 1'b0 || bus.cfg_err !== 1'b0) begin errors++; $display("FAIL pulse_width: got done=%b err=%b expected 0/0", bus.cfg_done, bus.cfg_err); end
        end
    endtask

    task automatic test_reset();
        reset_seq();
    endtask

    task automatic test_request(input logic [7:0] r);
        int w;
        @(negedge clk);
        accept(r, 1'b0, 8'd0, w);
        check_resp(1'b1);
    endtask

    task automatic test_back_to_back();
        int w;
        @(negedge clk);
        accept(8'd6, 1'b1, 8'd2, w);
        check_resp(1'b0);
        accept(8'd2, 1'b0, 8'd0, w);
        checks++; if (w != 0) begin errors++; $display("FAIL b2b_accept_wait: got %0d expected 0", w); end
        check_resp(1'b1);
    endtask

    task automatic test_reset_mid();
        int w;
        @(negedge clk);
        accept(8'd16, 1'b0, 8'd0, w);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (bus.div_ratio !== 8'd8 || bus.clk_en !== 1'b0) begin errors++; $display("FAIL midrst_async: got ratio=%0d en=%b expected 8/0", bus.div_ratio, bus.clk_en); end
        reset_seq();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_ratio = 8'd0;
        test_reset();
        test_request(8'd8);   // equal ratio shortcut
        test_request(8'd5);   // odd: rejected or rounded to 4
        test_request(8'd4);
        test_request(8'd0);
        test_request(8'd1);
        test_request(8'd7);
        test_back_to_back();
        test_reset_mid();
        test_request(8'd12);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
